// File: rtl/mult_pkg.sv
// Shared types and constants for the iterative shift-add / Booth multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Iteration counter width; counts 0 .. WIDTH-1.
  function automatic int CNT_W(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  // Booth step codes on {Q[0], q-1}.
  localparam logic [1:0] BOOTH_NOP0 = 2'b00;
  localparam logic [1:0] BOOTH_ADD  = 2'b01;
  localparam logic [1:0] BOOTH_SUB  = 2'b10;
  localparam logic [1:0] BOOTH_NOP1 = 2'b11;

endpackage

// File: rtl/mult_fsm.sv
// Control for seq_multiplier: state, iteration counter, busy/done, abort.
// load/step/last are combinational strobes consumed by the datapath registers.
module mult_fsm
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  output logic load,
  output logic step,
  output logic last
);

  localparam int CW = CNT_W(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        // abort is deliberately ignored here; start wins in IDLE/DONE
        if (start) begin
          state_d = CALC;
          cnt_d   = '0;
          load    = 1'b1;
        end
      end
      CALC: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          step = 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
            cnt_d   = '0;
            last    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == CALC);
      done_q  <= (state_d == DONE);
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: rtl/seq_multiplier.sv
// Iterative multiplier: one shift-add (unsigned) or radix-2 Booth (signed)
// step per clock; product registered and held until the next completion.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  logic load, step, last;

  mult_fsm #(.WIDTH(WIDTH)) u_fsm (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .load  (load),
    .step  (step),
    .last  (last)
  );

  logic [WIDTH-1:0]   m_q, q_q, q_d;
  logic [WIDTH:0]     a_q, a_d, m_ext, a_sum;
  logic               mode_q, qm1_q, qm1_d;
  logic [2*WIDTH-1:0] product_q;

  // A has one guard bit so Booth on M = -2^(WIDTH-1) cannot overflow,
  // and in unsigned mode the same bit holds the add carry.
  always_comb begin
    m_ext = mode_q ? {m_q[WIDTH-1], m_q} : {1'b0, m_q};
    a_sum = a_q;
    if (mode_q) begin
      unique case ({q_q[0], qm1_q})
        BOOTH_ADD: a_sum = a_q + m_ext;
        BOOTH_SUB: a_sum = a_q - m_ext;
        default:   a_sum = a_q;
      endcase
    end else if (q_q[0]) begin
      a_sum = a_q + m_ext;
    end
    a_d   = {mode_q & a_sum[WIDTH], a_sum[WIDTH:1]};
    q_d   = {a_sum[0], q_q[WIDTH-1:1]};
    qm1_d = q_q[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q       <= '0;
      q_q       <= '0;
      a_q       <= '0;
      mode_q    <= 1'b0;
      qm1_q     <= 1'b0;
      product_q <= '0;
    end else if (load) begin
      m_q    <= multiplicand;
      q_q    <= multiplier;
      mode_q <= signed_mode;
      a_q    <= '0;
      qm1_q  <= 1'b0;
    end else if (step) begin
      a_q   <= a_d;
      q_q   <= q_d;
      qm1_q <= qm1_d;
      if (last) product_q <= {a_d[WIDTH-1:0], q_d};
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier at WIDTH=8 and WIDTH=32: directed table, corner
// sequences (back-to-back, ignored start, abort, async reset) and random ops.
module tb_seq_multiplier;

  logic        clk = 1'b0, rst = 1'b1;
  logic        start8 = 0, sm8 = 0, ab8 = 0;
  logic [7:0]  mc8 = '0, mp8 = '0;
  logic        busy8, done8;
  logic [15:0] prod8;
  logic        start32 = 0, sm32 = 0, ab32 = 0;
  logic [31:0] mc32 = '0, mp32 = '0;
  logic        busy32, done32;
  logic [63:0] prod32;

  int cyc = 0, ntests = 0, nfail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_multiplier #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8), .abort(ab8),
    .multiplicand(mc8), .multiplier(mp8), .busy(busy8), .done(done8), .product(prod8));

  seq_multiplier #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .start(start32), .signed_mode(sm32), .abort(ab32),
    .multiplicand(mc32), .multiplier(mp32), .busy(busy32), .done(done32), .product(prod32));

  typedef struct {
    bit          s;
    logic [7:0]  a, b;
    logic [15:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain integer multiply of the operands as the mode interprets them.
  function automatic logic [63:0] ref_mul(input int w, input bit s, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ua, ub, r;
    longint      sa, sb;
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (w < 32) begin
      ua = ua & ((64'd1 << w) - 64'd1);
      ub = ub & ((64'd1 << w) - 64'd1);
    end
    if (s) begin
      sa = $signed(ua << (64 - w)) >>> (64 - w);
      sb = $signed(ub << (64 - w)) >>> (64 - w);
      r  = 64'(sa * sb);
    end else begin
      r = ua * ub;
    end
    if (w < 32) r = r & ((64'd1 << (2 * w)) - 64'd1);
    return r;
  endfunction

  task automatic drive(input int w, input bit st, input bit s, input logic [31:0] a,
                       input logic [31:0] b);
    if (w == 8) begin
      start8 = st; sm8 = s; mc8 = a[7:0]; mp8 = b[7:0];
    end else begin
      start32 = st; sm32 = s; mc32 = a; mp32 = b;
    end
  endtask

  function automatic bit busy_of(input int w);
    return (w == 8) ? busy8 : busy32;
  endfunction
  function automatic bit done_of(input int w);
    return (w == 8) ? done8 : done32;
  endfunction
  function automatic logic [63:0] prod_of(input int w);
    return (w == 8) ? {48'd0, prod8} : prod32;
  endfunction

  // gap = number of negedges to wait before raising start (0 = drive now).
  task automatic run(input int w, input int gap, input bit s, input logic [31:0] a,
                     input logic [31:0] b, output logic [63:0] p, output int lat,
                     output int bc, output int acc);
    repeat (gap) @(negedge clk);
    drive(w, 1'b1, s, a, b);
    @(posedge clk); #1;
    acc = cyc;
    drive(w, 1'b0, s, a, b);
    bc  = busy_of(w) ? 1 : 0;
    lat = 0;
    while (!done_of(w) && lat < 80) begin
      @(posedge clk); #1;
      lat++;
      if (!done_of(w) && busy_of(w)) bc++;
    end
    chk("busy_low_at_done", {63'd0, busy_of(w)}, 64'd0);
    p = prod_of(w);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        vt[4];
    logic [63:0] p;
    logic [31:0] a, b;
    int          lat, bc, acc, acc1, seen, w, gap;
    bit          s;

    vt[0] = '{s: 1'b0, a: 8'hFF, b: 8'hFF, exp: 16'hFE01};
    vt[1] = '{s: 1'b1, a: 8'hFD, b: 8'h05, exp: 16'hFFF1};
    vt[2] = '{s: 1'b1, a: 8'h80, b: 8'h80, exp: 16'h4000};
    vt[3] = '{s: 1'b1, a: 8'h80, b: 8'h7F, exp: 16'hC080};

    // Reset state
    #12;
    chk("rst_busy8", {63'd0, busy8}, 64'd0);
    chk("rst_done8", {63'd0, done8}, 64'd0);
    chk("rst_prod8", {48'd0, prod8}, 64'd0);
    chk("rst_prod32", prod32, 64'd0);
    @(negedge clk); rst = 1'b0;

    // Directed table
    for (int i = 0; i < 4; i++) begin
      run(8, 2, vt[i].s, {24'd0, vt[i].a}, {24'd0, vt[i].b}, p, lat, bc, acc);
      chk("tbl_prod", p, {48'd0, vt[i].exp});
      chk("tbl_latency", 64'(lat), 64'd8);
      chk("tbl_busy_cycles", 64'(bc), 64'd8);
    end

    // Zero product, then back-to-back start in the DONE cycle
    run(8, 2, 1'b0, 32'h00, 32'hAB, p, lat, bc, acc1);
    chk("zero_prod", p, 64'h0);
    run(8, 0, 1'b0, 32'd12, 32'd13, p, lat, bc, acc);
    chk("b2b_accept_gap", 64'(acc - acc1), 64'd9);
    chk("b2b_latency", 64'(lat), 64'd8);
    chk("b2b_prod", p, 64'h009C);

    // start during CALC is ignored
    @(negedge clk); @(negedge clk);
    drive(8, 1'b1, 1'b0, 32'd7, 32'd9);
    @(posedge clk); #1; acc = cyc;
    drive(8, 1'b0, 1'b0, 32'd7, 32'd9);
    repeat (3) begin @(posedge clk); #1; end
    drive(8, 1'b1, 1'b1, 32'hAA, 32'h55);
    @(posedge clk); #1;
    drive(8, 1'b0, 1'b0, 32'h0, 32'h0);
    while (!done8 && (cyc - acc) < 80) begin @(posedge clk); #1; end
    chk("ign_latency", 64'(cyc - acc), 64'd8);
    chk("ign_prod", {48'd0, prod8}, 64'h003F);
    @(posedge clk); #1;
    chk("ign_idle_after", {63'd0, busy8}, 64'd0);

    // abort mid-CALC
    @(negedge clk);
    drive(8, 1'b1, 1'b0, 32'd3, 32'd4);
    @(posedge clk); #1;
    drive(8, 1'b0, 1'b0, 32'd3, 32'd4);
    repeat (4) begin @(posedge clk); #1; end
    ab8 = 1'b1;
    @(posedge clk); #1;
    ab8 = 1'b0;
    chk("abort_busy", {63'd0, busy8}, 64'd0);
    chk("abort_done", {63'd0, done8}, 64'd0);
    chk("abort_prod_hold", {48'd0, prod8}, 64'h003F);
    seen = 0;
    repeat (12) begin @(posedge clk); #1; if (done8) seen++; end
    chk("abort_no_done", 64'(seen), 64'd0);
    run(8, 1, 1'b0, 32'd11, 32'd11, p, lat, bc, acc);
    chk("post_abort_prod", p, 64'h0079);
    chk("post_abort_latency", 64'(lat), 64'd8);

    // abort together with start in IDLE: start wins
    @(negedge clk); @(negedge clk);
    ab8 = 1'b1;
    drive(8, 1'b1, 1'b0, 32'd5, 32'd6);
    @(posedge clk); #1; acc = cyc;
    ab8 = 1'b0;
    drive(8, 1'b0, 1'b0, 32'd5, 32'd6);
    chk("abort_start_busy", {63'd0, busy8}, 64'd1);
    while (!done8 && (cyc - acc) < 80) begin @(posedge clk); #1; end
    chk("abort_start_prod", {48'd0, prod8}, 64'h001E);

    // asynchronous reset mid-CALC
    @(negedge clk);
    drive(8, 1'b1, 1'b0, 32'd200, 32'd3);
    drive(32, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
    @(posedge clk); #1;
    drive(8, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(32, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    chk("arst_busy8", {63'd0, busy8}, 64'd0);
    chk("arst_done8", {63'd0, done8}, 64'd0);
    chk("arst_prod8", {48'd0, prod8}, 64'd0);
    chk("arst_busy32", {63'd0, busy32}, 64'd0);
    @(negedge clk); rst = 1'b0;

    // Randomised ops against the reference model
    for (int wi = 0; wi < 2; wi++) begin
      w = (wi == 0) ? 8 : 32;
      for (int i = 0; i < 1000; i++) begin
        s = 1'($urandom_range(0, 1));
        a = $urandom;
        b = $urandom;
        if ($urandom_range(0, 7) == 0) a = (w == 8) ? 32'h80 : 32'h8000_0000;
        if ($urandom_range(0, 7) == 0) b = (w == 8) ? 32'hFF : 32'hFFFF_FFFF;
        gap = (i == 0) ? 1 : $urandom_range(0, 2);
        run(w, gap, s, a, b, p, lat, bc, acc);
        chk((w == 8) ? "rnd8_prod" : "rnd32_prod", p, ref_mul(w, s, a, b));
        chk((w == 8) ? "rnd8_latency" : "rnd32_latency", 64'(lat), 64'(w));
      end
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
